// File: rtl/conv_pkg.sv
// conv_pkg: shared tiling constants, ceil helper and FSM
// state encoding for the tiled convolution sequencer.
package conv_pkg;

    function automatic int ceil(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int DEF_AW = 32;
    localparam int DEF_N  = 16;
    localparam int DEF_TN = 8;
    localparam int DEF_M  = 16;
    localparam int DEF_TM = 8;
    localparam int DEF_R  = 32;
    localparam int DEF_TR = 16;
    localparam int DEF_C  = 16;
    localparam int DEF_TC = 8;
    localparam int DEF_K  = 3;
    localparam int DEF_S  = 1;

    localparam int TRK = (DEF_TR + DEF_S - DEF_K) / DEF_S;
    localparam int TCK = (DEF_TC + DEF_S - DEF_K) / DEF_S;
    localparam int ROW_STEP = TRK * DEF_S;
    localparam int COL_STEP = TCK * DEF_S;
    localparam int NT = ceil(DEF_N, DEF_TN);
    localparam int MT = ceil(DEF_M, DEF_TM);
    localparam int RT =
        ceil((DEF_R + DEF_S - DEF_K) / DEF_S, TRK);
    localparam int CT =
        ceil((DEF_C + DEF_S - DEF_K) / DEF_S, TCK);
    localparam int TILE_NUM = NT * MT * RT * CT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE,
        ST_FIN
    } state_t;

endpackage

// File: rtl/tile_cord_step.sv
// tile_cord_step: 4-level wrapping tile coordinate counter.
// col is fastest, then row, then m, then n.
module tile_cord_step #(
    parameter int AW    = 32,
    parameter int N_CNT = 2,
    parameter int M_CNT = 2,
    parameter int R_CNT = 3,
    parameter int C_CNT = 3,
    parameter int N_INC = 8,
    parameter int M_INC = 8,
    parameter int R_INC = 14,
    parameter int C_INC = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] base_n,
    output logic [AW-1:0] base_m,
    output logic [AW-1:0] base_row,
    output logic [AW-1:0] base_col,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] N_LAST = AW'(N_CNT - 1);
    localparam logic [AW-1:0] M_LAST = AW'(M_CNT - 1);
    localparam logic [AW-1:0] R_LAST = AW'(R_CNT - 1);
    localparam logic [AW-1:0] C_LAST = AW'(C_CNT - 1);
    localparam logic [AW-1:0] N_ST = AW'(N_INC);
    localparam logic [AW-1:0] M_ST = AW'(M_INC);
    localparam logic [AW-1:0] R_ST = AW'(R_INC);
    localparam logic [AW-1:0] C_ST = AW'(C_INC);

    logic [AW-1:0] n_i;
    logic [AW-1:0] m_i;
    logic [AW-1:0] r_i;
    logic [AW-1:0] c_i;
    logic          c_wrap;
    logic          r_wrap;
    logic          m_wrap;

    assign c_wrap = (c_i == C_LAST);
    assign r_wrap = c_wrap && (r_i == R_LAST);
    assign m_wrap = r_wrap && (m_i == M_LAST);

    // step the carry chain; clear returns to tile 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            n_i      <= '0;
            m_i      <= '0;
            r_i      <= '0;
            c_i      <= '0;
            base_n   <= '0;
            base_m   <= '0;
            base_row <= '0;
            base_col <= '0;
            idx      <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
            if (c_wrap) begin
                c_i      <= '0;
                base_col <= '0;
            end else begin
                c_i      <= c_i + 1'b1;
                base_col <= base_col + C_ST;
            end
            if (c_wrap) begin
                if (r_i == R_LAST) begin
                    r_i      <= '0;
                    base_row <= '0;
                end else begin
                    r_i      <= r_i + 1'b1;
                    base_row <= base_row + R_ST;
                end
            end
            if (r_wrap) begin
                if (m_i == M_LAST) begin
                    m_i    <= '0;
                    base_m <= '0;
                end else begin
                    m_i    <= m_i + 1'b1;
                    base_m <= base_m + M_ST;
                end
            end
            if (m_wrap) begin
                if (n_i == N_LAST) begin
                    n_i    <= '0;
                    base_n <= '0;
                end else begin
                    n_i    <= n_i + 1'b1;
                    base_n <= base_n + N_ST;
                end
            end
        end
    end

endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks every (n, m, row, col) tile of a
// layer, handshaking one tile at a time with conv_tile.
module conv_tile_sched
    import conv_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int N  = DEF_N,
    parameter int Tn = DEF_TN,
    parameter int M  = DEF_M,
    parameter int Tm = DEF_TM,
    parameter int R  = DEF_R,
    parameter int Tr = DEF_TR,
    parameter int C  = DEF_C,
    parameter int Tc = DEF_TC,
    parameter int K  = DEF_K,
    parameter int S  = DEF_S
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_start,
    input  logic          conv_tile_done,
    output logic          conv_tile_start,
    output logic [AW-1:0] tile_base_n,
    output logic [AW-1:0] tile_base_m,
    output logic [AW-1:0] tile_base_row,
    output logic [AW-1:0] tile_base_col,
    output logic [AW-1:0] tile_idx,
    output logic          conv_busy,
    output logic          conv_done
);

    localparam int P_TRK = (Tr + S - K) / S;
    localparam int P_TCK = (Tc + S - K) / S;
    localparam int P_NT = ceil(N, Tn);
    localparam int P_MT = ceil(M, Tm);
    localparam int P_RT = ceil((R + S - K) / S, P_TRK);
    localparam int P_CT = ceil((C + S - K) / S, P_TCK);
    localparam int P_TILES = P_NT * P_MT * P_RT * P_CT;
    localparam logic [AW-1:0] LAST_IDX = AW'(P_TILES - 1);

    state_t state_q;
    state_t state_d;
    logic   conv_start_q;
    logic   start_edge;
    logic   last_tile;
    logic   cord_step;
    logic   cord_clear;

    assign start_edge = conv_start && !conv_start_q;
    assign last_tile  = (tile_idx == LAST_IDX);

    // state register and start-edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_start_q <= conv_start;
        end
    end

    // next state and per-state outputs
    always_comb begin
        state_d         = state_q;
        conv_tile_start = 1'b0;
        conv_done       = 1'b0;
        conv_busy       = 1'b0;
        cord_step       = 1'b0;
        cord_clear      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                conv_tile_start = 1'b1;
                conv_busy       = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                conv_busy = 1'b1;
                if (conv_tile_done)
                    state_d = last_tile ? ST_FIN
                                        : ST_ADVANCE;
            end
            ST_ADVANCE: begin
                conv_busy = 1'b1;
                cord_step = 1'b1;
                state_d   = ST_ISSUE;
            end
            ST_FIN: begin
                conv_done  = 1'b1;
                conv_busy  = 1'b1;
                cord_clear = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    tile_cord_step #(
        .AW    (AW),
        .N_CNT (P_NT),
        .M_CNT (P_MT),
        .R_CNT (P_RT),
        .C_CNT (P_CT),
        .N_INC (Tn),
        .M_INC (Tm),
        .R_INC (P_TRK * S),
        .C_INC (P_TCK * S)
    ) u_cord (
        .clk      (clk),
        .rst      (rst),
        .clear    (cord_clear),
        .step     (cord_step),
        .base_n   (tile_base_n),
        .base_m   (tile_base_m),
        .base_row (tile_base_row),
        .base_col (tile_base_col),
        .idx      (tile_idx)
    );

endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: directed scenarios for the tile
// sequencer, default layer plus a single-tile layer.
module tb_conv_tile_sched;

    logic        clk;
    logic        rst;
    logic        conv_start;
    logic        conv_tile_done;
    logic        conv_tile_start;
    logic [31:0] tile_base_n;
    logic [31:0] tile_base_m;
    logic [31:0] tile_base_row;
    logic [31:0] tile_base_col;
    logic [31:0] tile_idx;
    logic        conv_busy;
    logic        conv_done;

    logic        start2;
    logic        tdone2;
    logic        tstart2;
    logic [31:0] bn2;
    logic [31:0] bm2;
    logic [31:0] br2;
    logic [31:0] bc2;
    logic [31:0] idx2;
    logic        busy2;
    logic        done2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int rec_n [64];
    int rec_m [64];
    int rec_r [64];
    int rec_c [64];
    int rec_i [64];
    bit rec_b [64];
    int st_cyc [64];
    int dn_cyc [64];
    int n_st;
    int n_dn;
    int n_fin;
    int fin_cyc;
    bit run_ok;

    conv_tile_sched dut (
        .clk             (clk),
        .rst             (rst),
        .conv_start      (conv_start),
        .conv_tile_done  (conv_tile_done),
        .conv_tile_start (conv_tile_start),
        .tile_base_n     (tile_base_n),
        .tile_base_m     (tile_base_m),
        .tile_base_row   (tile_base_row),
        .tile_base_col   (tile_base_col),
        .tile_idx        (tile_idx),
        .conv_busy       (conv_busy),
        .conv_done       (conv_done)
    );

    conv_tile_sched #(
        .N(8), .Tn(8), .M(8), .Tm(8),
        .R(8), .Tr(8), .C(8), .Tc(8)
    ) dut1 (
        .clk             (clk),
        .rst             (rst),
        .conv_start      (start2),
        .conv_tile_done  (tdone2),
        .conv_tile_start (tstart2),
        .tile_base_n     (bn2),
        .tile_base_m     (bm2),
        .tile_base_row   (br2),
        .tile_base_col   (bc2),
        .tile_idx        (idx2),
        .conv_busy       (busy2),
        .conv_done       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // conv_tile stand-in: done lat cycles after each start
    task automatic run_layer(input int lat,
                             input bit extra,
                             input bit toggle,
                             input int stop);
        int cnt;
        bit ext_pend;
        n_st = 0;
        n_dn = 0;
        n_fin = 0;
        fin_cyc = -100;
        cnt = 0;
        ext_pend = 1'b0;
        run_ok = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            tick();
            conv_tile_done = 1'b0;
            if (ext_pend) begin
                conv_tile_done = 1'b1;
                ext_pend = 1'b0;
            end
            if (conv_tile_start) begin
                if (n_st < 64) begin
                    rec_n[n_st] = int'(tile_base_n);
                    rec_m[n_st] = int'(tile_base_m);
                    rec_r[n_st] = int'(tile_base_row);
                    rec_c[n_st] = int'(tile_base_col);
                    rec_i[n_st] = int'(tile_idx);
                    rec_b[n_st] = conv_busy;
                    st_cyc[n_st] = cyc;
                end
                n_st++;
                cnt = lat;
                if (toggle) begin
                    if (n_st == 3 || n_st == 5)
                        conv_start = 1'b0;
                    if (n_st == 4 || n_st == 6)
                        conv_start = 1'b1;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_tile_done = 1'b1;
                    if (n_dn < 64) dn_cyc[n_dn] = cyc;
                    n_dn++;
                    ext_pend = extra;
                    if (toggle && n_st == 36)
                        conv_start = 1'b0;
                end
            end
            if (conv_done) begin
                n_fin++;
                fin_cyc = cyc;
                if (toggle) conv_start = 1'b1;
            end
            if (n_fin > 0 && cyc == fin_cyc + 6) begin
                run_ok = 1'b1;
                break;
            end
            if (stop > 0 && n_st == stop &&
                cyc == st_cyc[stop-1] + 1) begin
                run_ok = 1'b1;
                break;
            end
        end
        conv_tile_done = 1'b0;
    endtask

    task automatic new_edge();
        conv_start = 1'b0;
        tick();
        conv_start = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        conv_start = 1'b0;
        conv_tile_done = 1'b0;
        start2 = 1'b0;
        tdone2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if (conv_tile_start !== 1'b0 || conv_done !== 1'b0
            || conv_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got %b%b%b want 000",
                     conv_tile_start, conv_done, conv_busy);
        end
        total++;
        if (tile_idx !== 32'd0 || tile_base_n !== 32'd0 ||
            tile_base_m !== 32'd0 || tile_base_row !== 32'd0 ||
            tile_base_col !== 32'd0) begin
            bad++;
            $display("FAIL reset_coords idx=%0d n=%0d m=%0d r=%0d c=%0d want 0",
                     tile_idx, tile_base_n, tile_base_m,
                     tile_base_row, tile_base_col);
        end
    endtask

    task automatic test_idle_done();
        int seen;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            conv_tile_done = k[0];
            tick();
            if (conv_tile_start || conv_busy || conv_done)
                seen++;
        end
        conv_tile_done = 1'b0;
        total++;
        if (seen != 0 || tile_idx !== 32'd0) begin
            bad++;
            $display("FAIL idle_done activity=%0d idx=%0d want 0 0",
                     seen, tile_idx);
        end
    endtask

    task automatic test_full_run();
        int t0;
        int en;
        int em;
        int er;
        int ec;
        conv_start = 1'b1;
        t0 = cyc;
        run_layer(50, 1'b0, 1'b0, 0);
        total++;
        if (!run_ok || n_st != 36 || n_fin != 1) begin
            bad++;
            $display("FAIL full_counts ok=%0d starts=%0d dones=%0d want 1 36 1",
                     run_ok, n_st, n_fin);
        end
        for (int k = 0; k < 36; k++) begin
            ec = (k % 3) * 6;
            er = ((k / 3) % 3) * 14;
            em = ((k / 9) % 2) * 8;
            en = (k / 18) * 8;
            total++;
            if (rec_n[k] != en || rec_m[k] != em ||
                rec_r[k] != er || rec_c[k] != ec ||
                rec_i[k] != k) begin
                bad++;
                $display("FAIL tile%0d got %0d/%0d/%0d/%0d i%0d want %0d/%0d/%0d/%0d i%0d",
                         k, rec_n[k], rec_m[k], rec_r[k],
                         rec_c[k], rec_i[k], en, em, er, ec, k);
            end
        end
        total++;
        if (rec_r[3] != 14 || rec_c[3] != 0 ||
            rec_r[6] != 28 || rec_n[35] != 8 ||
            rec_m[35] != 8 || rec_r[35] != 28 ||
            rec_c[35] != 12) begin
            bad++;
            $display("FAIL key_tiles r3=%0d r6=%0d last=%0d/%0d/%0d/%0d want 14 28 8/8/28/12",
                     rec_r[3], rec_r[6], rec_n[35], rec_m[35],
                     rec_r[35], rec_c[35]);
        end
        total++;
        if (st_cyc[0] != t0 + 1 || rec_b[0] !== 1'b1) begin
            bad++;
            $display("FAIL first_start cyc=%0d busy=%b want %0d 1",
                     st_cyc[0], rec_b[0], t0 + 1);
        end
        total++;
        if (st_cyc[1] != dn_cyc[0] + 2 ||
            st_cyc[35] != dn_cyc[34] + 2) begin
            bad++;
            $display("FAIL done_to_start got %0d %0d want %0d %0d",
                     st_cyc[1], st_cyc[35],
                     dn_cyc[0] + 2, dn_cyc[34] + 2);
        end
        total++;
        if (fin_cyc != dn_cyc[35] + 1) begin
            bad++;
            $display("FAIL done_latency got %0d want %0d",
                     fin_cyc, dn_cyc[35] + 1);
        end
        total++;
        if (conv_busy !== 1'b0 || tile_idx !== 32'd0 ||
            tile_base_row !== 32'd0) begin
            bad++;
            $display("FAIL post_run busy=%b idx=%0d row=%0d want 0 0 0",
                     conv_busy, tile_idx, tile_base_row);
        end
    endtask

    task automatic test_spurious_adv();
        new_edge();
        run_layer(20, 1'b1, 1'b0, 0);
        total++;
        if (!run_ok || n_st != 36 || n_fin != 1 ||
            rec_i[35] != 35) begin
            bad++;
            $display("FAIL adv_done ok=%0d starts=%0d dones=%0d last=%0d want 1 36 1 35",
                     run_ok, n_st, n_fin, rec_i[35]);
        end
    endtask

    task automatic test_start_ignored();
        new_edge();
        run_layer(10, 1'b0, 1'b1, 0);
        total++;
        if (!run_ok || n_st != 36 || n_fin != 1) begin
            bad++;
            $display("FAIL toggle_run ok=%0d starts=%0d dones=%0d want 1 36 1",
                     run_ok, n_st, n_fin);
        end
        new_edge();
        run_layer(10, 1'b0, 1'b0, 0);
        total++;
        if (!run_ok || n_st != 36 || rec_n[0] != 0 ||
            rec_m[0] != 0 || rec_r[0] != 0 ||
            rec_c[0] != 0 || rec_i[0] != 0) begin
            bad++;
            $display("FAIL second_run ok=%0d starts=%0d t0=%0d/%0d/%0d/%0d want 1 36 0/0/0/0",
                     run_ok, n_st, rec_n[0], rec_m[0],
                     rec_r[0], rec_c[0]);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        new_edge();
        run_layer(50, 1'b0, 1'b0, 21);
        total++;
        if (!run_ok || tile_idx !== 32'd20 ||
            conv_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reach ok=%0d idx=%0d busy=%b want 1 20 1",
                     run_ok, tile_idx, conv_busy);
        end
        rst = 1'b1;
        conv_start = 1'b0;
        tick();
        rst = 1'b0;
        total++;
        if (conv_busy !== 1'b0 || conv_done !== 1'b0 ||
            conv_tile_start !== 1'b0 ||
            tile_idx !== 32'd0 || tile_base_n !== 32'd0 ||
            tile_base_m !== 32'd0 ||
            tile_base_row !== 32'd0 ||
            tile_base_col !== 32'd0) begin
            bad++;
            $display("FAIL mid_rst busy=%b done=%b st=%b idx=%0d want 0 0 0 0",
                     conv_busy, conv_done, conv_tile_start,
                     tile_idx);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (conv_done || conv_tile_start) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_quiet pulses=%0d want 0", seen);
        end
        new_edge();
        run_layer(5, 1'b0, 1'b0, 0);
        total++;
        if (!run_ok || n_st != 36 || n_fin != 1 ||
            rec_i[0] != 0 || rec_n[0] != 0 ||
            rec_r[0] != 0 || rec_c[0] != 0) begin
            bad++;
            $display("FAIL mid_restart ok=%0d starts=%0d i0=%0d want 1 36 0",
                     run_ok, n_st, rec_i[0]);
        end
    endtask

    task automatic test_single_tile();
        int t0;
        int ts;
        int extra;
        start2 = 1'b1;
        t0 = cyc;
        ts = -1;
        for (int k = 0; k < 10 && ts < 0; k++) begin
            tick();
            if (tstart2) ts = cyc;
        end
        total++;
        if (ts != t0 + 1 || bn2 !== 32'd0 || bm2 !== 32'd0
            || br2 !== 32'd0 || bc2 !== 32'd0 ||
            idx2 !== 32'd0) begin
            bad++;
            $display("FAIL single_start cyc=%0d idx=%0d want %0d 0",
                     ts, idx2, t0 + 1);
        end
        tick();
        tick();
        tdone2 = 1'b1;
        tick();
        tdone2 = 1'b0;
        total++;
        if (done2 !== 1'b1) begin
            bad++;
            $display("FAIL single_done got %b want 1", done2);
        end
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (tstart2 || done2) extra++;
        end
        total++;
        if (extra != 0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL single_tail pulses=%0d busy=%b want 0 0",
                     extra, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_idle_done();
        test_full_run();
        test_spurious_adv();
        test_start_ignored();
        test_rst_mid();
        test_single_tile();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
